ro_puf_eval: RTL and testbench
==============================

// Module: ro_puf_eval
// PURPOSE
//   Measurement engine for a ring-oscillator PUF array. Per response bit it selects an RO pair
//   by challenge, counts rising edges of each over a fixed clk window, compares and shifts the
//   result into a multi-bit response. It replaces the fixed single-pair count/compare path.
//   The RO array stays outside this block; this block drives its enable and samples its outputs.
// PARAMETERS
//   NUM_RO        8   number of oscillators on osc_in (power of 2, >=2)
//   RESP_BITS     4   response bits produced per challenge (1..NUM_RO/2)
//   CNT_W         8   edge-counter width
//   WINDOW_CYCLES 64  clk cycles per counting window (>=1)
//   SETTLE_CYCLES 4   clk cycles with osc_en high and counters cleared before each window (>=0)
//   MARGIN        2   weak-bit threshold (used only with RO_PUF_MARGIN_EN)
// PORTS
//   clk        in   1                 system clock
//   rst_n      in   1                 reset: asynchronous, active-high
//   start      in   1                 request evaluation; accepted only in IDLE
//   challenge  in   $clog2(NUM_RO)    base RO index; sampled when start is accepted
//   osc_in     in   NUM_RO            raw RO outputs, asynchronous to clk
//   osc_en     out  1                 enable to RO array
//   busy       out  1                 high from the cycle after acceptance until return to IDLE
//   resp       out  RESP_BITS         response; bit k from pair k
//   resp_valid out  1                 one-cycle pulse when resp is complete
//   weak_bits  out  RESP_BITS         only with RO_PUF_MARGIN_EN
// BEHAVIOUR
//   Reset: state=IDLE; osc_en, busy, resp, resp_valid, weak_bits, counters all 0. Reset mid-run
//     aborts immediately; no partial resp is kept.
//   Pair k: a=(chal+2k) mod NUM_RO, b=(chal+2k+1) mod NUM_RO; wrap-around by truncation.
//   Sampling: each selected osc passes a 2-FF synchroniser plus an edge-detect FF; one rising
//     edge = one count. Valid only if osc frequency < clk/4; faster inputs alias (not flagged).
//   FSM: IDLE -start-> SETTLE (or COUNT if SETTLE_CYCLES=0) -> COUNT -> CMP ->
//     SETTLE/COUNT for bit k+1, or DONE after bit RESP_BITS-1; DONE -> IDLE.
//   SETTLE: SETTLE_CYCLES cycles; osc_en=1; counters held at 0; edges ignored.
//   COUNT: exactly WINDOW_CYCLES cycles; counters increment on detected edges and saturate
//     at 2^CNT_W-1 (no wrap). Edges in the synchroniser when COUNT ends are discarded.
//   CMP: 1 cycle; resp[k] <= (cnt_a > cnt_b); tie -> 0; counters cleared at exit.
//   DONE: 1 cycle; resp_valid=1; osc_en=0. resp then holds until next accepted start,
//     which clears resp to 0 on acceptance.
//   osc_en is 1 in SETTLE, COUNT, CMP; 0 in IDLE and DONE.
//   Latency: start accepted at cycle 0 -> resp_valid at cycle
//     1 + RESP_BITS*(SETTLE_CYCLES+WINDOW_CYCLES+1); defaults: cycle 277.
//   start while busy/DONE: ignored, no queueing. challenge changes after acceptance: ignored.
//   start and reset together: reset wins.
// CONFIGURATION
//   RO_PUF_MARGIN_EN defined: port weak_bits exists; in CMP, weak_bits[k] <= (|cnt_a-cnt_b| < MARGIN),
//     computed at CNT_W+1 bits; cleared with resp on acceptance and reset.
//   Undefined: no weak_bits port, no difference logic; all other behaviour identical.
// TESTING
//   Defaults; osc[0] period 4 clk, osc[1] period 8 clk, others static; chal=0, start
//     -> resp_valid at cycle 277, resp[0]=1 (16 vs 8 edges), resp[3:1]=0 (ties).
//   Same stimulus, swap periods of osc[0]/osc[1] -> resp[0]=0.
//   chal=7, osc[7] period 4, osc[0] period 8 -> pair0=(7,0) wraps; resp[0]=1.
//   CNT_W=3, osc[0] period 4, osc[1] period 6 -> both saturate at 7; tie -> resp[0]=0.
//   Reset asserted at cycle 100 of a run -> all outputs 0 same cycle; no resp_valid;
//     new start after release completes normally at 277 cycles.
//   start pulsed at cycle 50 of a run -> ignored; exactly one resp_valid; with
//     RO_PUF_MARGIN_EN, 16 vs 15 edges -> resp[0]=1, weak_bits[0]=1.

Source files
------------

// File: rtl/ro_puf_eval_if.sv
// Host-side handshake bundle for the RO-PUF evaluation engine.
// weak_bits exists only when RO_PUF_MARGIN_EN is defined.
`timescale 1ns/1ps
interface ro_puf_eval_if #(
  parameter int unsigned NUM_RO    = 8,
  parameter int unsigned RESP_BITS = 4
);
  localparam int unsigned CHAL_W = $clog2(NUM_RO);

  logic                 start;
  logic [CHAL_W-1:0]    challenge;
  logic                 busy;
  logic [RESP_BITS-1:0] resp;
  logic                 resp_valid;
`ifdef RO_PUF_MARGIN_EN
  logic [RESP_BITS-1:0] weak_bits;

  modport master (output start, challenge, input busy, resp, resp_valid, weak_bits);
  modport slave  (input start, challenge, output busy, resp, resp_valid, weak_bits);
`else
  modport master (output start, challenge, input busy, resp, resp_valid);
  modport slave  (input start, challenge, output busy, resp, resp_valid);
`endif
endinterface

// File: rtl/ro_puf_eval.sv
// Ring-oscillator PUF measurement engine: per response bit, count edges of a challenge-selected
// RO pair over a fixed window and compare. Optional weak-bit flagging under RO_PUF_MARGIN_EN.
`timescale 1ns/1ps
module ro_puf_eval #(
  parameter int unsigned NUM_RO        = 8,
  parameter int unsigned RESP_BITS     = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned WINDOW_CYCLES = 64,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned MARGIN        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RO-1:0] osc_in,
  output logic              osc_en,
  ro_puf_eval_if.slave      bus
);

  localparam int unsigned CHAL_W = $clog2(NUM_RO);
  localparam int unsigned BIT_W  = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned PH_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PH_W   = $clog2(PH_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_CMP, S_DONE} state_t;

  state_t            state;
  logic [CHAL_W-1:0] chal_q;
  logic [BIT_W-1:0]  bit_k;
  logic [PH_W-1:0]   ph;
  logic [CNT_W-1:0]  cnt_a, cnt_b;
  logic [NUM_RO-1:0] sync1, sync2, sync3;
  logic [NUM_RO-1:0] rise;
  logic [CHAL_W-1:0] idx_a, idx_b;
  logic              rise_a, rise_b;

  // 2-FF synchroniser plus edge-detect stage on every oscillator input
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= osc_in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise   = sync2 & ~sync3;
  // Pair k = (chal+2k, chal+2k+1), wrapping by truncation to CHAL_W bits
  assign idx_a  = chal_q + CHAL_W'({bit_k, 1'b0});
  assign idx_b  = idx_a + CHAL_W'(1);
  assign rise_a = rise[idx_a];
  assign rise_b = rise[idx_b];

`ifdef RO_PUF_MARGIN_EN
  logic [CNT_W:0] diff;
  logic           weak;
  assign diff = (cnt_a >= cnt_b) ? ({1'b0, cnt_a} - {1'b0, cnt_b})
                                 : ({1'b0, cnt_b} - {1'b0, cnt_a});
  assign weak = (diff < (CNT_W+1)'(MARGIN));
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state          <= S_IDLE;
      chal_q         <= '0;
      bit_k          <= '0;
      ph             <= '0;
      cnt_a          <= '0;
      cnt_b          <= '0;
      osc_en         <= 1'b0;
      bus.busy       <= 1'b0;
      bus.resp       <= '0;
      bus.resp_valid <= 1'b0;
`ifdef RO_PUF_MARGIN_EN
      bus.weak_bits  <= '0;
`endif
    end else begin
      bus.resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            chal_q   <= bus.challenge;
            bit_k    <= '0;
            ph       <= '0;
            cnt_a    <= '0;
            cnt_b    <= '0;
            osc_en   <= 1'b1;
            bus.busy <= 1'b1;
            bus.resp <= '0;
`ifdef RO_PUF_MARGIN_EN
            bus.weak_bits <= '0;
`endif
            state    <= (SETTLE_CYCLES == 0) ? S_COUNT : S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (ph == PH_W'(SETTLE_CYCLES - 1)) begin
            ph    <= '0;
            state <= S_COUNT;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        S_COUNT: begin
          if (rise_a && (cnt_a != CNT_MAX)) cnt_a <= cnt_a + CNT_W'(1);
          if (rise_b && (cnt_b != CNT_MAX)) cnt_b <= cnt_b + CNT_W'(1);
          if (ph == PH_W'(WINDOW_CYCLES - 1)) begin
            ph    <= '0;
            state <= S_CMP;
          end else begin
            ph <= ph + PH_W'(1);
          end
        end
        S_CMP: begin
          bus.resp[bit_k] <= (cnt_a > cnt_b);
`ifdef RO_PUF_MARGIN_EN
          bus.weak_bits[bit_k] <= weak;
`endif
          cnt_a <= '0;
          cnt_b <= '0;
          if (bit_k == BIT_W'(RESP_BITS - 1)) begin
            osc_en         <= 1'b0;
            bus.resp_valid <= 1'b1;
            state          <= S_DONE;
          end else begin
            bit_k <= bit_k + BIT_W'(1);
            state <= (SETTLE_CYCLES == 0) ? S_COUNT : S_SETTLE;
          end
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_eval.sv
// Directed bench for ro_puf_eval: default instance plus a CNT_W=3 instance sharing the RO stimulus.
`timescale 1ns/1ps
module tb_ro_puf_eval;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] osc_in;
  logic       osc_en0, osc_en1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int hp [8];
  int skip_req [8];

  int         lat, pulses;
  logic [3:0] r0, r1, w0;

  ro_puf_eval_if #(.NUM_RO(8), .RESP_BITS(4)) b0 ();
  ro_puf_eval_if #(.NUM_RO(8), .RESP_BITS(4)) b1 ();

  ro_puf_eval dut0 (.clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_en(osc_en0), .bus(b0));
  ro_puf_eval #(.CNT_W(3)) dut1 (.clk(clk), .rst_n(rst_n), .osc_in(osc_in), .osc_en(osc_en1), .bus(b1));

  always #5 clk = ~clk;

  // Oscillator models: half period hp[g] ns (0 = static low); toggles stay 2 ns off the clk grid.
  // A skip request holds the line low for one extra period, removing exactly one rising edge.
  for (genvar g = 0; g < 8; g++) begin : g_osc
    logic o;
    int   done_n;
    assign osc_in[g] = o;
    initial begin
      o = 1'b0;
      done_n = 0;
      #2;
      forever begin
        if (hp[g] == 0) begin
          o = 1'b0;
          #10;
        end else begin
          #(hp[g]);
          if (!o && (skip_req[g] > done_n)) begin
            done_n++;
            #(2 * hp[g]);
          end
          o = ~o;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_periods(input int p0, input int p1, input int p7);
    for (int i = 0; i < 8; i++) hp[i] = 0;
    hp[0] = p0;
    hp[1] = p1;
    hp[7] = p7;
    repeat (10) @(negedge clk);
  endtask

  // One evaluation on both instances; cyc 0 is the cycle start is sampled in.
  task automatic run_eval(input logic [2:0] chal, input int poke_at, input int skip_at);
    @(negedge clk);
    b0.challenge = chal; b0.start = 1'b1;
    b1.challenge = chal; b1.start = 1'b1;
    cyc = 0;
    @(posedge clk); cyc = 1; @(negedge clk);
    b0.start = 1'b0; b1.start = 1'b0;
    b0.challenge = ~chal; b1.challenge = ~chal;
    chk("busy_after_accept", 32'(b0.busy), 32'd1);
    chk("resp_cleared_on_accept", 32'(b0.resp), 32'd0);
    chk("osc_en_running", 32'(osc_en0), 32'd1);
    lat = 0; pulses = 0; r0 = 'x; r1 = 'x; w0 = 'x;
    while (cyc < 360) begin
      if (b0.resp_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = cyc;
          r0  = b0.resp;
`ifdef RO_PUF_MARGIN_EN
          w0  = b0.weak_bits;
`endif
        end
      end
      if (b1.resp_valid) r1 = b1.resp;
      if (cyc == skip_at) skip_req[1]++;
      b0.start = (cyc == poke_at);
      @(posedge clk); cyc++; @(negedge clk);
    end
    b0.start = 1'b0;
    chk("osc_en_after_done", 32'(osc_en0), 32'd0);
    chk("busy_after_done", 32'(b0.busy), 32'd0);
    chk("resp_holds", 32'(b0.resp), 32'(r0));
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin hp[i] = 0; skip_req[i] = 0; end
    b0.start = 1'b0; b0.challenge = '0;
    b1.start = 1'b0; b1.challenge = '0;

    repeat (3) @(negedge clk);
    chk("rst_osc_en", 32'(osc_en0), 32'd0);
    chk("rst_busy", 32'(b0.busy), 32'd0);
    chk("rst_resp", 32'(b0.resp), 32'd0);
    chk("rst_resp_valid", 32'(b0.resp_valid), 32'd0);
    rst_n = 1'b0;

    // osc0 period 4 clk (16 edges), osc1 period 8 clk (8 edges)
    set_periods(20, 40, 0);
    run_eval(3'd0, -1, -1);
    chk("p1_latency", 32'(lat), 32'd277);
    chk("p1_pulses", 32'(pulses), 32'd1);
    chk("p1_resp", 32'(r0), 32'h1);
    chk("p1_sat_tie_resp", 32'(r1), 32'h0);
`ifdef RO_PUF_MARGIN_EN
    chk("p1_weak", 32'(w0), 32'he);
`endif

    set_periods(40, 20, 0);
    run_eval(3'd0, -1, -1);
    chk("swap_latency", 32'(lat), 32'd277);
    chk("swap_resp", 32'(r0), 32'h0);

    set_periods(40, 0, 20);
    run_eval(3'd7, -1, -1);
    chk("wrap_latency", 32'(lat), 32'd277);
    chk("wrap_resp", 32'(r0), 32'h1);

    // osc1 period 6 clk: 16 vs 10-11 unsaturated, 7 vs 7 at CNT_W=3
    set_periods(20, 30, 0);
    run_eval(3'd0, -1, -1);
    chk("p6_resp", 32'(r0), 32'h1);
    chk("sat_resp", 32'(r1), 32'h0);

    // Reset in the middle of a run
    set_periods(20, 40, 0);
    @(negedge clk);
    b0.challenge = 3'd0; b0.start = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk); cyc++; @(negedge clk);
      b0.start = 1'b0;
    end
    chk("pre_reset_busy", 32'(b0.busy), 32'd1);
    rst_n = 1'b1;
    #1;
    chk("midrst_osc_en", 32'(osc_en0), 32'd0);
    chk("midrst_busy", 32'(b0.busy), 32'd0);
    chk("midrst_resp", 32'(b0.resp), 32'd0);
    chk("midrst_resp_valid", 32'(b0.resp_valid), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (b0.resp_valid) pulses++;
    end
    chk("no_valid_after_abort", 32'(pulses), 32'd0);
    run_eval(3'd0, -1, -1);
    chk("post_reset_latency", 32'(lat), 32'd277);
    chk("post_reset_resp", 32'(r0), 32'h1);

    // Equal periods with one osc1 edge removed mid-window (16 vs 15); stray start at cycle 50
    set_periods(20, 20, 0);
    run_eval(3'd0, 50, 30);
    chk("poke_pulses", 32'(pulses), 32'd1);
    chk("poke_latency", 32'(lat), 32'd277);
    chk("poke_resp", 32'(r0), 32'h1);
`ifdef RO_PUF_MARGIN_EN
    chk("poke_weak", 32'(w0), 32'hf);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
